ahb3lite_interconnect_slave_port: RTL and testbench
===================================================

// Module: ahb3lite_interconnect_slave_port
// PURPOSE
//  Slave-side stage of the AHB3-Lite multi-layer switch: one instance per AHB slave. Collects requests from all
//  master ports, arbitrates by priority, grants one master, muxes its address/control (and data-phase HWDATA) to the
//  slave, and returns HRDATA/HREADYOUT/HRESP. Supplies the per-slave master_granted bit that each master port consumes.
// PARAMETERS
//  HADDR_SIZE   32  address width
//  HDATA_SIZE   32  data width
//  MASTERS      3   number of master ports
//  MASTER_BITS  $clog2(MASTERS)  priority/index width (localparam role)
// PORTS
//  HRESETn        in   1                       asynchronous active-low reset
//  HCLK           in   1                       clock, rising edge
//  mstpriority    in   [MASTERS][MASTER_BITS]  per-master priority (master port slvpriority)
//  mstHSEL        in   [MASTERS]               per-master request (master port slvHSEL[this slave])
//  mstHADDR/HWDATA/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK  in  [MASTERS][..]  per-master AHB signals
//  mstHREADY      in   [MASTERS]               per-master HREADY (master port slvHREADYOUT)
//  can_switch     in   [MASTERS]               owner permits re-arbitration next cycle
//  mstgnt         out  [MASTERS]               one-hot grant (drives master_granted[this slave])
//  mstHRDATA      out  HDATA_SIZE              broadcast read data
//  mstHREADYOUT   out  1                       broadcast slave HREADYOUT
//  mstHRESP       out  1                       broadcast slave HRESP
//  slv_HSEL/HADDR/HWDATA/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK  out  AHB widths  to slave
//  slv_HREADY     out  1                       HREADY into slave
//  slv_HREADYOUT  in   1 ; slv_HRESP in 1 ; slv_HRDATA in HDATA_SIZE   from slave
// BEHAVIOUR
//  - Reset: owner=0, owner_valid=0, data_owner=0; mstgnt=0, slv_HSEL=0, slv_HTRANS=IDLE, slv_HREADY=1, all other
//    muxed outputs follow master 0 (don't-care, but deterministic).
//  - Arbiter (comb): among masters with mstHSEL=1 choose max mstpriority; ties resolved per CONFIGURATION.
//  - switch_ok = ~owner_valid | can_switch[owner]. On posedge with switch_ok & slv_HREADYOUT & |mstHSEL:
//    owner<=winner, owner_valid<=1. No requests: owner held (bus parking), mstgnt stays on parked owner.
//  - mstgnt = owner_valid ? onehot(owner) : 0 (registered source, no comb path from mstHSEL to mstgnt).
//  - Address phase: slv_HSEL=owner_valid&mstHSEL[owner]; slv_HADDR..HMASTLOCK=mst*[owner];
//    slv_HTRANS=IDLE when slv_HSEL=0; slv_HREADY=owner_valid ? mstHREADY[owner] : 1.
//  - Data phase: data_owner<=owner on posedge when slv_HREADYOUT=1; slv_HWDATA=mstHWDATA[data_owner]. Latency 0
//    (pure mux) for address, 1 cycle owner lag for data, matching AHB pipelining.
//  - Returns: mstHRDATA=slv_HRDATA, mstHREADYOUT=slv_HREADYOUT, mstHRESP=slv_HRESP (broadcast; master ports qualify).
//  - Boundaries: slave wait-state (slv_HREADYOUT=0) freezes owner and data_owner even if can_switch; owner
//    drops HSEL with can_switch=0 -> owner kept; locked owner (can_switch=0) never pre-empted by higher priority;
//    simultaneous owner switch and data-phase -> data_owner takes OLD owner; reset mid-burst -> reset values at once.
// CONFIGURATION
//  AHB3LITE_SLVPORT_RR_EN defined: equal-top-priority ties resolved round-robin, search starts at owner+1 (mod
//   MASTERS); owner wins a tie only if no other tied requester.
//  Undefined: ties resolved fixed, lowest master index wins.
// STRUCTURE
//  - ahb3lite_pkg: HTRANS_*, HBURST_*, HRESP_* constants (existing); no new typedefs.
//  - Sub-module ahb3lite_interconnect_slave_arbiter: comb winner selection (priority + tie rule, macro lives here).
//  - Top: owner/data_owner regs, grant decode, address/data muxes.
// TESTING
//  1 Reset: HRESETn=0 -> mstgnt=000, slv_HSEL=0, slv_HTRANS=IDLE, slv_HREADY=1.
//  2 M0 prio0, M2 prio2 request NONSEQ SINGLE, no owner -> next cycle mstgnt=100, slv_HADDR=M2 addr.
//  3 M1 owns, INCR4 can_switch=0, M2 prio2 requests -> grant stays 010 until can_switch=1, then 100 next cycle.
//  4 Slave HREADYOUT=0 for 3 cycles during switch -> owner/data_owner frozen; slv_HWDATA stays old owner's data.
//  5 M0,M1,M2 equal prio, constant requests, can_switch=1: RR_EN -> grants 001,010,100,001; else 001 forever.
//  6 Write M1 then switch to M0: cycle after switch slv_HWDATA=M1 HWDATA, slv_HADDR=M0 address.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings used by the interconnect blocks.
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
endpackage

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Combinational winner selection: highest priority requester wins.
// AHB3LITE_SLVPORT_RR_EN selects round-robin tie breaking; otherwise the lowest index wins ties.
module ahb3lite_interconnect_slave_arbiter
  import ahb3lite_pkg::*;
#(
  parameter int MASTERS = 3,
  localparam int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic [MASTERS-1:0]     req_i,
  input  logic [MASTER_BITS-1:0] prio_i [MASTERS],
  input  logic [MASTER_BITS-1:0] owner_i,
  input  logic                   owner_valid_i,
  output logic [MASTER_BITS-1:0] winner_o,
  output logic                   any_req_o
);

  logic [MASTER_BITS-1:0] best;
  logic                   found;

`ifdef AHB3LITE_SLVPORT_RR_EN
  int                     base_i;
  int                     idx_i;
  logic [MASTER_BITS-1:0] idx;
  logic                   done;

  always_comb begin
    winner_o  = '0;
    any_req_o = |req_i;
    best      = '0;
    found     = 1'b0;
    base_i    = 0;
    idx_i     = 0;
    idx       = '0;
    done      = 1'b0;
    for (int i = 0; i < MASTERS; i++) begin
      if (req_i[i] && (!found || prio_i[i] > best)) begin
        best  = prio_i[i];
        found = 1'b1;
      end
    end
    // Search starts just past the current owner, so the owner is the last tied candidate.
    base_i = owner_valid_i ? int'(owner_i) + 1 : 0;
    if (base_i >= MASTERS) base_i = 0;
    for (int j = 0; j < MASTERS; j++) begin
      idx_i = base_i + j;
      if (idx_i >= MASTERS) idx_i = idx_i - MASTERS;
      idx = MASTER_BITS'(idx_i);
      if (!done && req_i[idx] && prio_i[idx] == best) begin
        winner_o = idx;
        done     = 1'b1;
      end
    end
  end
`else
  logic unused_owner;
  assign unused_owner = ^{owner_i, owner_valid_i};

  always_comb begin
    winner_o  = '0;
    any_req_o = |req_i;
    best      = '0;
    found     = 1'b0;
    // Strict compare keeps the lowest index on equal priority.
    for (int i = 0; i < MASTERS; i++) begin
      if (req_i[i] && (!found || prio_i[i] > best)) begin
        best     = prio_i[i];
        found    = 1'b1;
        winner_o = MASTER_BITS'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/ahb3lite_interconnect_slave_port.sv
// Slave-side stage of the AHB3-Lite switch: arbitrates masters, muxes address/data, broadcasts responses.
// Tie breaking is round-robin when AHB3LITE_SLVPORT_RR_EN is defined, fixed lowest-index otherwise.
module ahb3lite_interconnect_slave_port
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MASTERS    = 3,
  localparam int MASTER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic                   HRESETn,
  input  logic                   HCLK,
  input  logic [MASTER_BITS-1:0] mstpriority [MASTERS],
  input  logic [MASTERS-1:0]     mstHSEL,
  input  logic [HADDR_SIZE-1:0]  mstHADDR    [MASTERS],
  input  logic [HDATA_SIZE-1:0]  mstHWDATA   [MASTERS],
  input  logic [MASTERS-1:0]     mstHWRITE,
  input  logic [2:0]             mstHSIZE    [MASTERS],
  input  logic [2:0]             mstHBURST   [MASTERS],
  input  logic [3:0]             mstHPROT    [MASTERS],
  input  logic [1:0]             mstHTRANS   [MASTERS],
  input  logic [MASTERS-1:0]     mstHMASTLOCK,
  input  logic [MASTERS-1:0]     mstHREADY,
  input  logic [MASTERS-1:0]     can_switch,
  output logic [MASTERS-1:0]     mstgnt,
  output logic [HDATA_SIZE-1:0]  mstHRDATA,
  output logic                   mstHREADYOUT,
  output logic                   mstHRESP,
  output logic                   slv_HSEL,
  output logic [HADDR_SIZE-1:0]  slv_HADDR,
  output logic [HDATA_SIZE-1:0]  slv_HWDATA,
  output logic                   slv_HWRITE,
  output logic [2:0]             slv_HSIZE,
  output logic [2:0]             slv_HBURST,
  output logic [3:0]             slv_HPROT,
  output logic [1:0]             slv_HTRANS,
  output logic                   slv_HMASTLOCK,
  output logic                   slv_HREADY,
  input  logic                   slv_HREADYOUT,
  input  logic                   slv_HRESP,
  input  logic [HDATA_SIZE-1:0]  slv_HRDATA
);

  logic [MASTER_BITS-1:0] owner_q, owner_d;
  logic [MASTER_BITS-1:0] data_owner_q, data_owner_d;
  logic                   owner_valid_q, owner_valid_d;
  logic [MASTER_BITS-1:0] winner;
  logic                   any_req;
  logic                   switch_ok;

  ahb3lite_interconnect_slave_arbiter #(
    .MASTERS (MASTERS)
  ) u_arbiter (
    .req_i         (mstHSEL),
    .prio_i        (mstpriority),
    .owner_i       (owner_q),
    .owner_valid_i (owner_valid_q),
    .winner_o      (winner),
    .any_req_o     (any_req)
  );

  assign switch_ok = ~owner_valid_q | can_switch[owner_q];

  // A slave wait state freezes both owners; the data owner always inherits the pre-switch owner.
  always_comb begin
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    data_owner_d  = data_owner_q;
    if (slv_HREADYOUT) begin
      data_owner_d = owner_q;
      if (switch_ok && any_req) begin
        owner_d       = winner;
        owner_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
      data_owner_q  <= '0;
    end else begin
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
      data_owner_q  <= data_owner_d;
    end
  end

  always_comb begin
    mstgnt = '0;
    if (owner_valid_q) mstgnt[owner_q] = 1'b1;
  end

  assign slv_HSEL      = owner_valid_q & mstHSEL[owner_q];
  assign slv_HADDR     = mstHADDR[owner_q];
  assign slv_HWRITE    = mstHWRITE[owner_q];
  assign slv_HSIZE     = mstHSIZE[owner_q];
  assign slv_HBURST    = mstHBURST[owner_q];
  assign slv_HPROT     = mstHPROT[owner_q];
  assign slv_HTRANS    = slv_HSEL ? mstHTRANS[owner_q] : HTRANS_IDLE;
  assign slv_HMASTLOCK = mstHMASTLOCK[owner_q];
  assign slv_HREADY    = owner_valid_q ? mstHREADY[owner_q] : 1'b1;
  assign slv_HWDATA    = mstHWDATA[data_owner_q];

  assign mstHRDATA    = slv_HRDATA;
  assign mstHREADYOUT = slv_HREADYOUT;
  assign mstHRESP     = slv_HRESP;

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_port.sv
// Bench for ahb3lite_interconnect_slave_port: directed scenarios plus randomized traffic vs a behavioural model.
module tb_ahb3lite_interconnect_slave_port;
  localparam int M  = 3;
  localparam int MB = 2;

  logic          HRESETn, HCLK;
  logic [MB-1:0] mstpriority [M];
  logic [M-1:0]  mstHSEL, mstHWRITE, mstHMASTLOCK, mstHREADY, can_switch;
  logic [31:0]   mstHADDR [M];
  logic [31:0]   mstHWDATA [M];
  logic [2:0]    mstHSIZE [M];
  logic [2:0]    mstHBURST [M];
  logic [3:0]    mstHPROT [M];
  logic [1:0]    mstHTRANS [M];
  logic [M-1:0]  mstgnt;
  logic [31:0]   mstHRDATA, slv_HADDR, slv_HWDATA, slv_HRDATA;
  logic          mstHREADYOUT, mstHRESP, slv_HSEL, slv_HWRITE, slv_HMASTLOCK, slv_HREADY;
  logic [2:0]    slv_HSIZE, slv_HBURST;
  logic [3:0]    slv_HPROT;
  logic [1:0]    slv_HTRANS;
  logic          slv_HREADYOUT, slv_HRESP;

  int n_cmp = 0;
  int n_err = 0;
  int m_owner, m_downer;
  bit m_valid;

  ahb3lite_interconnect_slave_port #(.HADDR_SIZE(32), .HDATA_SIZE(32), .MASTERS(M)) dut (
    .HRESETn(HRESETn), .HCLK(HCLK), .mstpriority(mstpriority), .mstHSEL(mstHSEL),
    .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA), .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE),
    .mstHBURST(mstHBURST), .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS), .mstHMASTLOCK(mstHMASTLOCK),
    .mstHREADY(mstHREADY), .can_switch(can_switch), .mstgnt(mstgnt), .mstHRDATA(mstHRDATA),
    .mstHREADYOUT(mstHREADYOUT), .mstHRESP(mstHRESP), .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR),
    .slv_HWDATA(slv_HWDATA), .slv_HWRITE(slv_HWRITE), .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST),
    .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS), .slv_HMASTLOCK(slv_HMASTLOCK),
    .slv_HREADY(slv_HREADY), .slv_HREADYOUT(slv_HREADYOUT), .slv_HRESP(slv_HRESP),
    .slv_HRDATA(slv_HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Highest priority among requesters; ties by index order (round-robin from owner+1 when enabled).
  function automatic int model_winner();
    int top = -1;
    int start = 0;
    for (int i = 0; i < M; i++)
      if (mstHSEL[i] && int'(mstpriority[i]) > top) top = int'(mstpriority[i]);
`ifdef AHB3LITE_SLVPORT_RR_EN
    start = m_valid ? (m_owner + 1) % M : 0;
`endif
    for (int k = 0; k < M; k++)
      if (mstHSEL[(start + k) % M] && int'(mstpriority[(start + k) % M]) == top) return (start + k) % M;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_valid = 0; m_downer = 0;
  endtask

  task automatic model_update();
    int w;
    if (!HRESETn) begin
      model_reset();
    end else if (slv_HREADYOUT) begin
      w = model_winner();
      m_downer = m_owner;
      if ((!m_valid || can_switch[m_owner]) && w >= 0) begin
        m_owner = w;
        m_valid = 1;
      end
    end
  endtask

  task automatic check_model();
    logic e_sel;
    e_sel = m_valid && mstHSEL[m_owner];
    chk("mstgnt", 64'(mstgnt), m_valid ? 64'(1 << m_owner) : 64'd0);
    chk("slv_HSEL", 64'(slv_HSEL), 64'(e_sel));
    chk("slv_HADDR", 64'(slv_HADDR), 64'(mstHADDR[m_owner]));
    chk("slv_HWRITE", 64'(slv_HWRITE), 64'(mstHWRITE[m_owner]));
    chk("slv_HSIZE", 64'(slv_HSIZE), 64'(mstHSIZE[m_owner]));
    chk("slv_HBURST", 64'(slv_HBURST), 64'(mstHBURST[m_owner]));
    chk("slv_HPROT", 64'(slv_HPROT), 64'(mstHPROT[m_owner]));
    chk("slv_HTRANS", 64'(slv_HTRANS), e_sel ? 64'(mstHTRANS[m_owner]) : 64'd0);
    chk("slv_HMASTLOCK", 64'(slv_HMASTLOCK), 64'(mstHMASTLOCK[m_owner]));
    chk("slv_HREADY", 64'(slv_HREADY), m_valid ? 64'(mstHREADY[m_owner]) : 64'd1);
    chk("slv_HWDATA", 64'(slv_HWDATA), 64'(mstHWDATA[m_downer]));
    chk("mstHRDATA", 64'(mstHRDATA), 64'(slv_HRDATA));
    chk("mstHREADYOUT", 64'(mstHREADYOUT), 64'(slv_HREADYOUT));
    chk("mstHRESP", 64'(mstHRESP), 64'(slv_HRESP));
  endtask

  task automatic step();
    @(posedge HCLK);
    model_update();
    @(negedge HCLK);
    check_model();
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < M; i++) begin
      mstpriority[i] = MB'($urandom_range(0, 3));
      mstHADDR[i]    = $urandom;
      mstHWDATA[i]   = $urandom;
      mstHSIZE[i]    = 3'($urandom_range(0, 7));
      mstHBURST[i]   = 3'($urandom_range(0, 7));
      mstHPROT[i]    = 4'($urandom_range(0, 15));
      mstHTRANS[i]   = 2'($urandom_range(0, 3));
      mstHSEL[i]     = ($urandom_range(0, 1) == 1);
      mstHWRITE[i]   = ($urandom_range(0, 1) == 1);
      mstHMASTLOCK[i] = ($urandom_range(0, 3) == 0);
      mstHREADY[i]   = ($urandom_range(0, 3) != 0);
      can_switch[i]  = ($urandom_range(0, 9) < 7);
    end
    slv_HREADYOUT = ($urandom_range(0, 3) != 0);
    slv_HRESP     = ($urandom_range(0, 7) == 0);
    slv_HRDATA    = $urandom;
  endtask

  logic [M-1:0] rr_exp [4];

  initial begin
    HRESETn = 1'b0;
    for (int i = 0; i < M; i++) begin
      mstpriority[i] = '0;
      mstHADDR[i]    = 32'h1000_0000 + 32'(i) * 32'h100;
      mstHWDATA[i]   = 32'hA0A0_0000 + 32'(i) * 32'h0101_1111;
      mstHSIZE[i]    = 3'd2;
      mstHBURST[i]   = 3'd0;
      mstHPROT[i]    = 4'h3;
      mstHTRANS[i]   = 2'd0;
    end
    mstHSEL = '0; mstHWRITE = '0; mstHMASTLOCK = '0; mstHREADY = '1; can_switch = '1;
    slv_HREADYOUT = 1'b1; slv_HRESP = 1'b0; slv_HRDATA = 32'hDEAD_BEEF;
    model_reset();

    // Reset state
    @(negedge HCLK);
    check_model();
    chk("rst_gnt", 64'(mstgnt), 64'd0);
    chk("rst_hsel", 64'(slv_HSEL), 64'd0);
    chk("rst_htrans", 64'(slv_HTRANS), 64'd0);
    chk("rst_hready", 64'(slv_HREADY), 64'd1);
    HRESETn = 1'b1;

    // M0 prio0 vs M2 prio2 from idle
    mstHSEL = 3'b101; mstpriority[0] = 2'd0; mstpriority[2] = 2'd2;
    mstHTRANS[0] = 2'd2; mstHTRANS[2] = 2'd2;
    step();
    chk("t2_gnt", 64'(mstgnt), 64'b100);
    chk("t2_haddr", 64'(slv_HADDR), 64'h1000_0200);

    // M1 takes ownership, then locks out a higher-priority M2
    mstHSEL = 3'b010; mstpriority[1] = 2'd3; mstHBURST[1] = 3'b011; mstHTRANS[1] = 2'd2;
    step();
    chk("t3_take", 64'(mstgnt), 64'b010);
    can_switch = 3'b101; mstpriority[1] = 2'd1; mstpriority[2] = 2'd3; mstHSEL = 3'b110; mstHTRANS[1] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_locked", 64'(mstgnt), 64'b010);
    end
    mstHSEL = 3'b100;
    step();
    chk("t3_drop_gnt", 64'(mstgnt), 64'b010);
    chk("t3_drop_htrans", 64'(slv_HTRANS), 64'd0);
    can_switch = 3'b111;
    step();
    chk("t3_release", 64'(mstgnt), 64'b100);

    // Wait states freeze a pending switch from M2 to M0
    step();
    mstHSEL = 3'b101; mstpriority[0] = 2'd3; mstpriority[2] = 2'd0; slv_HREADYOUT = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_frozen_gnt", 64'(mstgnt), 64'b100);
      chk("t4_frozen_wdata", 64'(slv_HWDATA), 64'hA2A2_2222);
    end
    slv_HREADYOUT = 1'b1;
    step();
    chk("t4_switch_gnt", 64'(mstgnt), 64'b001);
    chk("t4_old_wdata", 64'(slv_HWDATA), 64'hA2A2_2222);
    step();
    chk("t4_new_wdata", 64'(slv_HWDATA), 64'hA0A0_0000);

    // Write from M1, then switch to M0: data phase lags address phase
    mstHSEL = 3'b010; mstpriority[1] = 2'd3; mstpriority[0] = 2'd0; mstHWRITE = 3'b010;
    step();
    step();
    mstHSEL = 3'b001; mstpriority[0] = 2'd3;
    step();
    chk("t6_gnt", 64'(mstgnt), 64'b001);
    chk("t6_wdata", 64'(slv_HWDATA), 64'hA1A1_1111);
    chk("t6_haddr", 64'(slv_HADDR), 64'h1000_0000);

    // Equal priorities, constant requests, from a fresh reset
    HRESETn = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("t5_rst_gnt", 64'(mstgnt), 64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
`ifdef AHB3LITE_SLVPORT_RR_EN
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
`else
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b001; rr_exp[2] = 3'b001; rr_exp[3] = 3'b001;
`endif
    mstHSEL = 3'b111; can_switch = 3'b111;
    for (int i = 0; i < M; i++) mstpriority[i] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_tie_gnt", 64'(mstgnt), 64'(rr_exp[k]));
    end

    // Randomized traffic, including asynchronous resets mid-transfer
    for (int c = 0; c < 3000; c++) begin
      randomize_inputs();
      if (HRESETn && $urandom_range(0, 99) == 0) begin
        HRESETn = 1'b0;
        #1;
        model_reset();
        check_model();
      end else if (!HRESETn && $urandom_range(0, 1) == 1) begin
        HRESETn = 1'b1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
